count_tick_gen: RTL
===================

// Module: count_tick_gen
// PURPOSE
//  Parametrised successor of the switch-selected count/compare block.
//  Generates a one-clock o_valid pulse every N prescaled ticks; N is picked from 4 limits by i_sw.
//  Adds a clock prescaler, a periodic/one-shot mode, limit latching per period, and busy/count visibility.
//  Drives LED blink and test-strobe logic at top level.
// PARAMETERS
//  DATA_WIDTH   32    width of count and limit values
//  R0           3     limit for i_sw=2'b00 (ticks per period)
//  R1           10    limit for i_sw=2'b01
//  R2           100   limit for i_sw=2'b10
//  R3           5000  limit for i_sw=2'b11
//  PRESC_WIDTH  8     width of prescaler divider input
// PORTS
//  clock     in   1            system clock, rising edge
//  i_reset   in   1            asynchronous, active-low reset
//  i_enable  in   1            0: force IDLE and clear counters; 1: allow operation
//  i_sw      in   2            limit select R0..R3
//  i_mode    in   1            0 periodic, 1 one-shot
//  i_start   in   1            one-shot trigger, level sampled each clock
//  i_presc   in   PRESC_WIDTH  tick every i_presc+1 clocks (0 = every clock)
//  o_valid   out  1            1-clock pulse at end of each period, registered
//  o_busy    out  1            high while state==RUN
//  o_count   out  DATA_WIDTH   current tick count within period
// BEHAVIOUR
//  Reset (i_reset=0): immediate, asynchronous.
//   - State=IDLE; o_valid, o_busy, o_count, prescaler, limit_q and mode_q all 0.
//  FSM states: IDLE, RUN.
//   - IDLE->RUN when i_enable=1 and (mode=periodic, or mode=one-shot with i_start=1).
//   - On that edge: count<=0, presc_cnt<=0, limit_q<=R[i_sw], mode_q<=i_mode.
//   - RUN->IDLE when i_enable=0, or at the one-shot terminal tick.
//  Tick: asserted on an edge in RUN where presc_cnt==i_presc; presc_cnt then wraps to 0, else increments.
//  Count: increments on each tick.
//   - On the tick where count==limit_q-1: count<=0 and o_valid<=1 for exactly one clock.
//   - Periodic: limit_q<=R[i_sw] re-latched at the same time.
//  A limit of 0 is treated as 1.
//  Latency: enable sampled at edge k, i_presc=0, limit L gives o_valid high after edges k+L, k+2L, ...
//  i_sw changes mid-period take effect only at the next period; the current period is never truncated.
//  i_mode is latched at IDLE->RUN; changing it in RUN has no effect until IDLE.
//  i_start while in RUN is ignored (no retrigger).
//  i_enable=0 on the same edge as a terminal tick: disable wins, o_valid stays 0, count<=0.
//  i_presc changes take effect immediately.
//   - If presc_cnt > new i_presc, presc_cnt counts up, wraps at its all-ones value and restarts from 0 (no tick lost silently).
//  Count and prescaler arithmetic is unsigned and wraps modulo 2^width. Comparisons are equality only.
// CONFIGURATION
//  COUNT_TICK_TOGGLE_EN defined: adds port o_toggle (out, 1), reset 0.
//   - o_toggle inverts on every edge that raises o_valid (50% blink output).
//  COUNT_TICK_TOGGLE_EN undefined: o_toggle port and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package count_pkg holds:
//   - FSM state encodings ST_IDLE/ST_RUN
//   - mode constants MODE_PERIODIC/MODE_ONESHOT
//   - select codes SW_R0..SW_R3
//  Sub-module count_prescaler (PRESC_WIDTH): inputs clock, i_reset, i_clear, i_presc; output o_tick.
//  Limit select mux and FSM/counter stay in the top module.
// TESTING
//  1. Periodic, i_sw=00, i_presc=0, enable at edge k -> o_valid high after k+3, k+6, k+9; o_count cycles 0,1,2.
//  2. Periodic, i_sw=11, i_presc=1 -> o_valid spacing exactly 10000 clocks; o_busy stays 1.
//  3. One-shot, i_sw=01, i_start pulse -> single o_valid 10 clocks later; o_busy 1 for 10 clocks, then 0.
//     A second i_start at clock 4 is ignored.
//  4. Periodic at i_sw=01, switch to 00 when o_count=5 -> current period ends at 10 ticks, following periods are 3.
//  5. i_enable dropped on the terminal tick edge -> no o_valid; o_count=0; o_busy=0 next cycle.
//  6. i_reset low mid-count (o_count=57, i_sw=10) -> all outputs 0 without a clock edge; restart gives full 100-tick period.
//     With COUNT_TICK_TOGGLE_EN, o_toggle also returns to 0.

Source files
------------

// File: rtl/count_pkg.sv
// Shared encodings for the count/tick generator: FSM states, mode and limit-select codes.
package count_pkg;
  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_RUN        = 1'b1;
  localparam logic [0:0] MODE_PERIODIC = 1'b0;
  localparam logic [0:0] MODE_ONESHOT  = 1'b1;
  localparam logic [1:0] SW_R0 = 2'b00;
  localparam logic [1:0] SW_R1 = 2'b01;
  localparam logic [1:0] SW_R2 = 2'b10;
  localparam logic [1:0] SW_R3 = 2'b11;

  // A zero limit would never match count==limit-1 sensibly, so it behaves as 1.
  function automatic int unsigned lim_nz(input int unsigned r);
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/count_prescaler.sv
// Clock prescaler: o_tick every i_presc+1 clocks while not cleared; i_presc is used live.
module count_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic                   o_tick
);
  logic [PRESC_WIDTH-1:0] r_cnt;

  assign o_tick = !i_clear && (r_cnt == i_presc);

  // A shrunk i_presc below r_cnt lets the counter run on and wrap through zero.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)                r_cnt <= '0;
    else if (i_clear || o_tick)  r_cnt <= '0;
    else                         r_cnt <= r_cnt + PRESC_WIDTH'(1);
  end
endmodule

// File: rtl/count_tick_gen.sv
// Switch-selected tick generator: one-clock o_valid every N prescaled ticks, periodic or one-shot.
// Optional blink output o_toggle when COUNT_TICK_TOGGLE_EN is defined.
module count_tick_gen
  import count_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned R0          = 3,
  parameter int unsigned R1          = 10,
  parameter int unsigned R2          = 100,
  parameter int unsigned R3          = 5000,
  parameter int          PRESC_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [1:0]             i_sw,
  input  logic                   i_mode,
  input  logic                   i_start,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic [DATA_WIDTH-1:0]  o_count
`ifdef COUNT_TICK_TOGGLE_EN
  ,output logic                  o_toggle
`endif
);
  localparam logic [DATA_WIDTH-1:0] LIM0 = DATA_WIDTH'(lim_nz(R0));
  localparam logic [DATA_WIDTH-1:0] LIM1 = DATA_WIDTH'(lim_nz(R1));
  localparam logic [DATA_WIDTH-1:0] LIM2 = DATA_WIDTH'(lim_nz(R2));
  localparam logic [DATA_WIDTH-1:0] LIM3 = DATA_WIDTH'(lim_nz(R3));

  logic [0:0]            r_state;
  logic [0:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_limit;
  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] w_lim;
  logic                  w_tick;
  logic                  w_last;
  logic                  w_fire;

  always_comb begin
    w_lim = LIM0;
    case (i_sw)
      SW_R0:   w_lim = LIM0;
      SW_R1:   w_lim = LIM1;
      SW_R2:   w_lim = LIM2;
      SW_R3:   w_lim = LIM3;
      default: w_lim = LIM0;
    endcase
  end

  count_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (r_state != ST_RUN),
    .i_presc (i_presc),
    .o_tick  (w_tick)
  );

  assign w_last = (r_count == r_limit - DATA_WIDTH'(1));
  // Disable on the terminal edge suppresses the pulse.
  assign w_fire = (r_state == ST_RUN) && i_enable && w_tick && w_last;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_PERIODIC;
      r_limit <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          if (i_enable && (i_mode == MODE_PERIODIC || i_start)) begin
            r_state <= ST_RUN;
            r_limit <= w_lim;
            r_mode  <= i_mode;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (w_tick) begin
            if (w_last) begin
              r_count <= '0;
              r_valid <= 1'b1;
              if (r_mode == MODE_ONESHOT) r_state <= ST_IDLE;
              else                        r_limit <= w_lim;
            end else begin
              r_count <= r_count + DATA_WIDTH'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_busy  = (r_state == ST_RUN);
  assign o_count = r_count;

`ifdef COUNT_TICK_TOGGLE_EN
  logic r_toggle;
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset)    r_toggle <= 1'b0;
    else if (w_fire) r_toggle <= ~r_toggle;
  end
  assign o_toggle = r_toggle;
`endif
endmodule
